db_line_rd: RTL and testbench
=============================

# db_line_rd

Read-side sequencer for the deblocking output line buffer (`mem_bilo_db`). After one LCU's deblocked 4x4 blocks have been written, it walks the buffer's 8-bit read address space in raster line order. It absorbs the buffer's one-cycle read latency and forwards 32-pixel half-lines over a valid/ready stream to the store/DMA stage. Two read windows exist: the current LCU (luma 64x64, then interleaved UV) and the top extra lines.

## Interface

Parameters:
- `PIX_W`, default 8: pixel bit width; the line word is `PIX_W*32` bits.

Ports:
- `clk`, input, 1: clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `start_i`, input, 1: one-cycle pulse that starts a scan; ignored while `busy_o`=1.
- `sel_i`, input, 1: window select, sampled on `start_i`; 0 = current LCU (192 lines), 1 = top lines (16 lines).
- `busy_o`, output, 1: scan in progress.
- `done_o`, output, 1: one-cycle pulse when the last line is accepted downstream.
- `ren_o`, output, 1: buffer read enable.
- `raddr_o`, output, 8: buffer read address.
- `rdata_i`, input, `PIX_W*32`: buffer read data, valid the cycle after `ren_o`.
- `line_valid_o`, output, 1: output line valid.
- `line_ready_i`, input, 1: downstream ready.
- `line_data_o`, output, `PIX_W*32`: 32 pixels, leftmost pixel in the MSBs.
- `line_chroma_o`, output, 1: 0 = luma line, 1 = chroma (UV-interleaved) line.
- `line_row_o`, output, 6: row index within the plane/window.
- `line_half_o`, output, 1: 0 = left 32 pixels, 1 = right 32 pixels.

## Operation

- States and transitions:
  - IDLE: `start_i` latches `sel_i`, clears the read counter `cnt`, and moves to RUN.
  - RUN: issues reads until `cnt` = last; moves to DRAIN.
  - DRAIN: waits until the FIFO is empty and no read is in flight, pulses `done_o`, and returns to IDLE.
- Address map for the current window (`cnt` 0..191):
  - `cnt` < 128 (luma): row r=`cnt[6:1]`, half h=`cnt[0]`; `raddr` = {0, r[5], h, r[4:0]}.
  - `cnt` ≥ 128 (chroma): k=`cnt`-128, r=k[6:1] (0..31), h=k[0]; `raddr` = {2'b10, r[4:2], h, r[1:0]}.
- Address map for the top window (`cnt` 0..15):
  - Luma for `cnt` < 8, chroma for `cnt` ≥ 8.
  - l=`cnt[2:1]`, h=`cnt[0]`; `raddr` = 192 + 8·`cnt[3]` + 4·h + l.
- Issue rule: `ren_o`=1 in RUN only when FIFO occupancy plus in-flight reads is less than 2. `cnt` increments on each issued read.
- Sideband: `line_chroma_o`, `line_row_o` and `line_half_o` are computed at issue time and travel with the read through a one-stage pipe. They are pushed into the FIFO together with `rdata_i`.
- Output FIFO: 2 entries, fall-through. `line_valid_o` is high whenever the FIFO is non-empty. An entry is popped on `line_valid_o & line_ready_i`.
- Boundary conditions:
  - A simultaneous push and pop with the FIFO full is allowed.
  - `start_i` during RUN or DRAIN has no effect.
  - Asserting reset mid-scan abandons the scan and flushes the FIFO and any in-flight read.

## Timing

- Reset value of every output is 0, including `raddr_o` and `line_data_o`.
- Start-up: `start_i` in cycle t puts the first `ren_o` in t+1, and `line_valid_o` first rises in t+2.
- With `line_ready_i` held high, throughput is 1 line/cycle. The last line is accepted at t+1+N (N = 192 or 16), and `done_o` pulses in the following cycle.
- Backpressure: `line_valid_o` and the line payload hold stable while `line_ready_i`=0. No read is ever lost or reissued.
- `ren_o` never asserts while the credit count is 2.
- Back-to-back scans: a new `start_i` is accepted in the cycle after `done_o`.

## Structure

- Shared package (`enc_defines`): pixel width; line count constants `DB_CUR_LINES`=192 and `DB_TOP_LINES`=16; window base addresses 0, 128, 192 and 200.
- Natural sub-module: `db_line_fifo2`, a 2-entry fall-through FIFO with data and sideband, holding count plus full/empty logic.
- FSM, counter and address map stay in the top module.

## Test plan

- Current window, `line_ready_i` always 1: 192 lines in order. Line 0 has `raddr` 0; line 1 has `raddr` 32, half=1; line 128 has `raddr` 128, chroma=1; line 191 has `raddr` 191. `done_o` occurs exactly at t+194.
- Top window: 16 reads with addresses 192,196,193,197,…,203,207. Chroma=1 from the 9th line onward.
- Random `line_ready_i` (50%): data matches the preloaded pattern and nothing is dropped or duplicated. Credits never exceed 2, and the payload is stable while stalled.
- `line_ready_i`=0 for 20 cycles after start: exactly 2 reads are issued and `ren_o` then stays low. On release, lines resume in order.
- `start_i` pulsed mid-scan: ignored, with line count still 192.
- Reset asserted at line 50: all outputs are 0 immediately. A fresh `start_i` then yields a clean 192-line scan.

Source files
------------

// File: rtl/enc_defines.sv
// Shared encoder constants and types for the deblocking line-buffer read path.
package enc_defines;

    localparam int DB_PIX_W     = 8;
    localparam int DB_CUR_LINES = 192;
    localparam int DB_TOP_LINES = 16;

    localparam logic [7:0] DB_BASE_LUMA   = 8'd0;
    localparam logic [7:0] DB_BASE_CHROMA = 8'd128;
    localparam logic [7:0] DB_BASE_TOP    = 8'd192;
    localparam logic [7:0] DB_BASE_TOP_UV = 8'd200;

    typedef struct packed {
        logic       chroma;
        logic [5:0] row;
        logic       half;
    } line_sb_t;

endpackage

// File: rtl/db_line_fifo2.sv
// Two-entry fall-through FIFO carrying a line word plus its sideband.
module db_line_fifo2
    import enc_defines::*;
#(
    parameter int DW = 256
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  line_sb_t      push_sb,
    input  logic          ready,
    output logic          valid,
    output logic [DW-1:0] data,
    output line_sb_t      sb,
    output logic [1:0]    count
);

    logic [1:0][DW-1:0] mem;
    line_sb_t [1:0]     sb_mem;
    logic               wr_ptr, rd_ptr;
    logic               empty, pop, store, drop;

    assign empty = (count == 2'd0);
    assign valid = !empty || push;
    assign data  = !empty ? mem[rd_ptr]    : (push ? push_data : '0);
    assign sb    = !empty ? sb_mem[rd_ptr] : (push ? push_sb   : '0);
    assign pop   = valid && ready;
    // A word arriving into an empty FIFO and taken the same cycle bypasses storage.
    assign store = push && !(empty && pop);
    assign drop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            sb_mem <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (store) begin
                mem[wr_ptr]    <= push_data;
                sb_mem[wr_ptr] <= push_sb;
                wr_ptr         <= ~wr_ptr;
            end
            if (drop)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, store} - {1'b0, drop};
        end
    end

endmodule

// File: rtl/db_line_rd.sv
// Deblocking line-buffer read sequencer: walks the buffer in raster line order
// and streams 32-pixel half-lines downstream through a credit-limited FIFO.
module db_line_rd
    import enc_defines::*;
#(
    parameter int PIX_W = DB_PIX_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              sel_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              ren_o,
    output logic [7:0]        raddr_o,
    input  logic [PIX_W*32-1:0] rdata_i,
    output logic              line_valid_o,
    input  logic              line_ready_i,
    output logic [PIX_W*32-1:0] line_data_o,
    output logic              line_chroma_o,
    output logic [5:0]        line_row_o,
    output logic              line_half_o
);

    localparam int LW = PIX_W * 32;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t     state, state_nx;
    logic       sel_q;
    logic [7:0] cnt, last;
    logic       rd_vld;
    line_sb_t   sb_cur, sb_pipe, line_sb;
    logic [7:0] addr_cur;
    logic [1:0] fifo_cnt, credits;
    logic       issue;

    assign last    = sel_q ? 8'(DB_TOP_LINES - 1) : 8'(DB_CUR_LINES - 1);
    assign credits = fifo_cnt + {1'b0, rd_vld};
    assign issue   = (state == RUN) && (credits < 2'd2);

    // Address map; in the chroma part of the current window cnt[6] is 0, so cnt-128 = cnt[5:0].
    always_comb begin
        addr_cur = '0;
        sb_cur   = '0;
        if (!sel_q) begin
            sb_cur.row  = cnt[6:1];
            sb_cur.half = cnt[0];
            if (!cnt[7]) begin
                addr_cur = DB_BASE_LUMA + {1'b0, cnt[6], cnt[0], cnt[5:1]};
            end else begin
                sb_cur.chroma = 1'b1;
                addr_cur      = DB_BASE_CHROMA + {2'b00, cnt[5:3], cnt[0], cnt[2:1]};
            end
        end else begin
            sb_cur.chroma = cnt[3];
            sb_cur.row    = {4'b0, cnt[2:1]};
            sb_cur.half   = cnt[0];
            addr_cur      = (cnt[3] ? DB_BASE_TOP_UV : DB_BASE_TOP) + {5'b0, cnt[0], cnt[2:1]};
        end
    end

    always_comb begin
        state_nx = state;
        done_o   = 1'b0;
        case (state)
            IDLE:  if (start_i) state_nx = RUN;
            RUN:   if (issue && cnt == last) state_nx = DRAIN;
            DRAIN: if (fifo_cnt == 2'd0 && !rd_vld) begin
                done_o   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sel_q   <= 1'b0;
            cnt     <= '0;
            rd_vld  <= 1'b0;
            sb_pipe <= '0;
        end else begin
            state  <= state_nx;
            rd_vld <= issue;
            if (state == IDLE && start_i) begin
                sel_q <= sel_i;
                cnt   <= '0;
            end else if (issue) begin
                cnt <= cnt + 8'd1;
            end
            if (issue)
                sb_pipe <= sb_cur;
        end
    end

    assign busy_o  = (state != IDLE);
    assign ren_o   = issue;
    assign raddr_o = issue ? addr_cur : '0;

    db_line_fifo2 #(.DW(LW)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rd_vld),
        .push_data (rdata_i),
        .push_sb   (sb_pipe),
        .ready     (line_ready_i),
        .valid     (line_valid_o),
        .data      (line_data_o),
        .sb        (line_sb),
        .count     (fifo_cnt)
    );

    assign line_chroma_o = line_sb.chroma;
    assign line_row_o    = line_sb.row;
    assign line_half_o   = line_sb.half;

endmodule

// File: tb/tb_db_line_rd.sv
// Scoreboard bench for db_line_rd: a buffer model answers reads, expected lines
// come from the window layout and are checked as the DUT hands them downstream.
module tb_db_line_rd;

    localparam int PIX_W = 8;
    localparam int LW    = PIX_W * 32;

    typedef struct {
        logic [LW-1:0] data;
        logic          chroma;
        logic [5:0]    row;
        logic          half;
    } exp_t;

    logic          clk, rst_n, start_i, sel_i, busy_o, done_o, ren_o;
    logic [7:0]    raddr_o;
    logic [LW-1:0] rdata_i, line_data_o;
    logic          line_valid_o, line_ready_i, line_chroma_o, line_half_o;
    logic [5:0]    line_row_o;

    logic [LW-1:0] mem [256];
    exp_t          exp_q[$];
    int            vectors = 0, miscompares = 0;
    int            cyc = 0, nissued = 0, naccepted = 0, stall_until = 0;
    bit            rand_ready = 0;

    db_line_rd #(.PIX_W(PIX_W)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .sel_i(sel_i),
        .busy_o(busy_o), .done_o(done_o), .ren_o(ren_o), .raddr_o(raddr_o),
        .rdata_i(rdata_i), .line_valid_o(line_valid_o), .line_ready_i(line_ready_i),
        .line_data_o(line_data_o), .line_chroma_o(line_chroma_o),
        .line_row_o(line_row_o), .line_half_o(line_half_o)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Buffer model: one-cycle read latency, garbage when not reading.
    initial begin
        logic       p_ren;
        logic [7:0] p_addr;
        rdata_i = '0;
        forever begin
            @(negedge clk);
            p_ren  = ren_o;
            p_addr = raddr_o;
            @(posedge clk); #1;
            if (p_ren) begin
                rdata_i = mem[p_addr];
                nissued++;
            end else begin
                rdata_i = {8{$urandom}};
            end
        end
    end

    initial begin
        line_ready_i = 1;
        forever begin
            @(posedge clk); #1;
            if (cyc < stall_until)  line_ready_i = 0;
            else if (rand_ready)    line_ready_i = 1'($urandom_range(0, 1));
            else                    line_ready_i = 1;
        end
    end

    // Monitor: credit limit, stall stability, and in-order line payload.
    initial begin
        logic [LW+7:0] hold;
        bit            have_hold = 0;
        exp_t          e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                have_hold = 0;
            end else begin
                if (ren_o) chk("credit_limit", 64'((nissued - naccepted) < 2), 64'd1);
                if (have_hold)
                    chk("stall_hold", {62'd0, line_valid_o,
                        ({line_data_o, line_chroma_o, line_row_o, line_half_o} === hold)}, 64'd3);
                have_hold = line_valid_o && !line_ready_i;
                hold = {line_data_o, line_chroma_o, line_row_o, line_half_o};
                if (line_valid_o && line_ready_i) begin
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL extra_line: got row %0d chroma %0d with nothing expected",
                                 line_row_o, line_chroma_o);
                    end else begin
                        e = exp_q.pop_front();
                        if (line_data_o !== e.data || line_chroma_o !== e.chroma ||
                            line_row_o !== e.row || line_half_o !== e.half) begin
                            miscompares++;
                            $display("FAIL line: got %h c%0d r%0d h%0d, expected %h c%0d r%0d h%0d",
                                     line_data_o, line_chroma_o, line_row_o, line_half_o,
                                     e.data, e.chroma, e.row, e.half);
                        end
                    end
                    naccepted++;
                end
            end
        end
    end

    // Reference: raster order of each window, address from the plane layout.
    task automatic push_expect(input logic sel);
        exp_t e;
        int   r, h, a, c;
        if (!sel) begin
            for (int i = 0; i < 192; i++) begin
                h = i % 2;
                if (i < 128) begin
                    r = i / 2;          c = 0;
                    a = (r / 32) * 64 + h * 32 + r % 32;
                end else begin
                    r = (i - 128) / 2;  c = 1;
                    a = 128 + (r / 4) * 8 + h * 4 + r % 4;
                end
                e.data = mem[a]; e.chroma = 1'(c); e.row = 6'(r); e.half = 1'(h);
                exp_q.push_back(e);
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                r = (i / 2) % 4; h = i % 2; c = i / 8;
                a = 192 + 8 * c + 4 * h + r;
                e.data = mem[a]; e.chroma = 1'(c); e.row = 6'(r); e.half = 1'(h);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic scan(input logic sel, input bit chk_lat, input bit stall,
                        input bit midstart, input int rst_at);
        int n, t, done_cyc;
        bit got;
        n = sel ? 16 : 192;
        push_expect(sel);
        nissued = 0; naccepted = 0;
        if (stall) stall_until = cyc + 22;
        @(posedge clk); #1;
        start_i = 1; sel_i = sel; t = cyc;
        @(posedge clk); #1;
        start_i = 0; sel_i = $urandom_range(0, 1);
        @(negedge clk);
        chk("first_ren", {62'd0, ren_o, line_valid_o}, 64'd2);
        @(negedge clk);
        chk("first_valid", 64'(line_valid_o), 64'd1);
        if (stall) begin
            while (cyc < t + 20) @(negedge clk);
            chk("stall_reads", 64'(nissued), 64'd2);
        end
        if (midstart) begin
            while (cyc < t + 60) @(negedge clk);
            @(posedge clk); #1; start_i = 1; sel_i = ~sel;
            @(posedge clk); #1; start_i = 0;
        end
        if (rst_at > 0) begin
            for (int i = 0; i < 5000 && naccepted < rst_at; i++) @(negedge clk);
            chk("reach_rst_point", 64'(naccepted >= rst_at), 64'd1);
            @(posedge clk); #1;
            rst_n = 0;
            #1;
            chk("rst_outputs", {52'd0, |line_data_o, ren_o, |raddr_o, line_valid_o,
                line_chroma_o, |line_row_o, line_half_o, busy_o, done_o}, 64'd0);
            exp_q.delete();
            repeat (3) @(posedge clk);
            #1;
            nissued = 0; naccepted = 0;
            rst_n = 1;
            return;
        end
        got = 0; done_cyc = 0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            if (done_o) begin got = 1; done_cyc = cyc; end
        end
        chk("done_seen", 64'(got), 64'd1);
        if (chk_lat) chk("done_cycle", 64'(done_cyc - t), 64'(n + 2));
        chk("line_count", 64'(naccepted), 64'(n));
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        miscompares++;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = {{7{$urandom}}, 24'($urandom), 8'(i)};
        rst_n = 0; start_i = 0; sel_i = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_state", {52'd0, |line_data_o, ren_o, |raddr_o, line_valid_o,
            line_chroma_o, |line_row_o, line_half_o, busy_o, done_o}, 64'd0);
        @(posedge clk); #1; rst_n = 1;

        scan(0, 1, 0, 0, 0);           // current window, full throughput
        scan(1, 1, 0, 0, 0);           // top window, back-to-back
        rand_ready = 1;
        scan(0, 0, 0, 0, 0);
        scan(1, 0, 0, 0, 0);
        rand_ready = 0;
        scan(0, 0, 1, 0, 0);           // 20-cycle stall after start
        scan(0, 1, 0, 1, 0);           // start pulse mid-scan ignored
        rand_ready = 1;
        scan(0, 0, 0, 0, 50);          // reset at line 50
        rand_ready = 0;
        scan(0, 1, 0, 0, 0);           // clean scan after reset

        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
